key_ff_bank: RTL and testbench

//  Multi-channel successor to the single-key latch/flip-flop board demo. Each of CHANNELS raw

---
 rtl/key_ff_bank_pkg.sv | 30 +++
 rtl/key_debounce.sv | 62 ++++++
 rtl/key_ff_bank.sv | 113 +++++++++++
 tb/tb_key_ff_bank.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_ff_bank_pkg.sv
// Shared definitions for the key/LED flip-flop bank: LED mode encoding and
// the helpers that turn clock/timing parameters into cycle counts and widths.
package key_ff_bank_pkg;

  // Per-channel LED register behaviour, two bits per channel on the mode bus.
  typedef enum logic [1:0] {
    MODE_LEVEL  = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_SR     = 2'b10,
    MODE_SAMPLE = 2'b11
  } mode_e;

  localparam int MAX_CHANNELS = 16;

  // Debounce length in clock cycles.
  function automatic int calc_db(input int clk_hz, input int debounce_ms);
    return (clk_hz / 1000) * debounce_ms;
  endfunction

  // Blink half period in clock cycles.
  function automatic int calc_half(input int clk_hz, input int blink_hz);
    return clk_hz / (2 * blink_hz);
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton channel: two-flop synchroniser (inverted to an active-high
// pressed level), debounce counter and a one-cycle press pulse. The next-state
// stable level and rising pulse are exported so the LED logic in the parent
// can update on the same edge that registers the press.
module key_debounce
  import key_ff_bank_pkg::*;
#(
  parameter int DB = 4,
  parameter int CW = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic stable_o,
  output logic stable_nxt_o,
  output logic press_o,
  output logic rise_nxt_o
);

  localparam logic [CW-1:0] DB_LAST = CW'(DB - 1);

  logic [1:0]    sync_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, rise_d;

  // Count consecutive cycles where the synced level disagrees with the
  // debounced level; accept the new level after DB of them.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == DB_LAST) begin
        stable_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    rise_d = stable_d & ~stable_q;
  end

  // Synchroniser, debounce state and press pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= 2'b00;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], ~key_n_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= rise_d;
    end
  end

  assign stable_o     = stable_q;
  assign stable_nxt_o = stable_d;
  assign press_o      = press_q;
  assign rise_nxt_o   = rise_d;

endmodule

// File: rtl/key_ff_bank.sv
// Multi-channel key-to-LED bank. Each key is debounced in its own
// key_debounce instance; a shared divider produces the visible blink clock
// and a one-cycle tick used by channels in sample mode.
module key_ff_bank
  import key_ff_bank_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BLINK_HZ    = 1,
  parameter int DEBOUNCE_MS = 20,
  parameter int CHANNELS    = 4
) (
  input  logic                  clk50M,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   keys_n,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clr,
  output logic                  ledCLK,
  output logic [CHANNELS-1:0]   ledQ,
  output logic [CHANNELS-1:0]   press
);

  localparam int DB     = calc_db(CLK_HZ, DEBOUNCE_MS);
  localparam int HALF   = calc_half(CLK_HZ, BLINK_HZ);
  localparam int DB_W   = cnt_width(DB);
  localparam int HALF_W = cnt_width(HALF);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF - 1);

  // Parameter sanity: stop elaboration on impossible timing or channel count.
  if (DB < 1) begin : g_bad_db
    $error("key_ff_bank: debounce length must be at least one cycle");
  end
  if (HALF < 1) begin : g_bad_half
    $error("key_ff_bank: blink half period must be at least one cycle");
  end
  if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_ch
    $error("key_ff_bank: CHANNELS must be in 1..16");
  end

  logic [CHANNELS-1:0] stable;
  logic [CHANNELS-1:0] stable_nxt;
  logic [CHANNELS-1:0] rise_nxt;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    key_debounce #(
      .DB (DB),
      .CW (DB_W)
    ) u_db (
      .clk_i        (clk50M),
      .rst_i        (rst),
      .key_n_i      (keys_n[g]),
      .stable_o     (stable[g]),
      .stable_nxt_o (stable_nxt[g]),
      .press_o      (press[g]),
      .rise_nxt_o   (rise_nxt[g])
    );
  end

  logic [HALF_W-1:0] blink_cnt_q, blink_cnt_d;
  logic              ledclk_q, ledclk_d;
  logic              tick;

  // Blink divider: wrap at HALF-1, toggle the blink clock and emit a tick.
  always_comb begin
    tick        = (blink_cnt_q == HALF_LAST);
    blink_cnt_d = tick ? '0 : blink_cnt_q + HALF_W'(1);
    ledclk_d    = tick ? ~ledclk_q : ledclk_q;
  end

  // Blink divider registers.
  always_ff @(posedge clk50M) begin
    if (rst) begin
      blink_cnt_q <= '0;
      ledclk_q    <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      ledclk_q    <= ledclk_d;
    end
  end

  logic [CHANNELS-1:0] ledq_q, ledq_d;

  // Per-channel LED next state. Level/toggle/SR react to the debounced value
  // being registered this edge; sample mode takes the current debounced
  // value on the blink tick, like a flip-flop clocked by ledCLK.
  always_comb begin
    ledq_d = ledq_q;
    for (int i = 0; i < CHANNELS; i++) begin
      case (mode_e'(mode[2*i +: 2]))
        MODE_LEVEL:  ledq_d[i] = stable_nxt[i];
        MODE_TOGGLE: if (rise_nxt[i]) ledq_d[i] = ~ledq_q[i];
        MODE_SR: begin
          if (clr[i])           ledq_d[i] = 1'b0;
          else if (rise_nxt[i]) ledq_d[i] = 1'b1;
        end
        MODE_SAMPLE: if (tick) ledq_d[i] = stable[i];
        default:     ledq_d[i] = ledq_q[i];
      endcase
    end
  end

  // LED registers.
  always_ff @(posedge clk50M) begin
    if (rst) begin
      ledq_q <= '0;
    end else begin
      ledq_q <= ledq_d;
    end
  end

  assign ledCLK = ledclk_q;
  assign ledQ   = ledq_q;

endmodule

// File: tb/tb_key_ff_bank.sv
// Bench for key_ff_bank: directed scenarios followed by randomized key
// activity, every cycle compared against a window-based behavioural model.
module tb_key_ff_bank;

  localparam int CH   = 4;
  localparam int DB   = 4;
  localparam int HALF = 10;

  logic          clk = 1'b0;
  logic          rst_r;
  logic [CH-1:0] keys_r;
  logic [2*CH-1:0] mode_r;
  logic [CH-1:0] clr_r;
  logic          ledCLK;
  logic [CH-1:0] ledQ;
  logic [CH-1:0] press;

  key_ff_bank #(
    .CLK_HZ      (1000),
    .BLINK_HZ    (50),
    .DEBOUNCE_MS (4),
    .CHANNELS    (CH)
  ) dut (
    .clk50M (clk),
    .rst    (rst_r),
    .keys_n (keys_r),
    .mode   (mode_r),
    .clr    (clr_r),
    .ledCLK (ledCLK),
    .ledQ   (ledQ),
    .press  (press)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: pressed-level history per key; debounced level flips once the DB
  // samples seen by the debouncer (two cycles of sync delay) all disagree.
  logic [31:0]   hist [CH];
  logic [CH-1:0] m_stable, m_ledq, m_press;
  logic          m_ledclk;
  int            m_c;

  task automatic model_edge();
    logic [CH-1:0] old_st, new_st;
    logic          all_diff, m_tick;
    if (rst_r) begin
      for (int i = 0; i < CH; i++) hist[i] = '0;
      m_stable = '0; m_ledq = '0; m_press = '0; m_ledclk = 1'b0; m_c = 0;
    end else begin
      m_c++;
      m_tick   = (m_c % HALF) == 0;
      m_ledclk = ((m_c / HALF) % 2) == 1;
      old_st   = m_stable;
      for (int i = 0; i < CH; i++) begin
        hist[i]  = {hist[i][30:0], ~keys_r[i]};
        all_diff = 1'b1;
        for (int k = 2; k <= DB + 1; k++)
          if (hist[i][k] == old_st[i]) all_diff = 1'b0;
        new_st[i] = all_diff ? ~old_st[i] : old_st[i];
      end
      m_press = new_st & ~old_st;
      for (int i = 0; i < CH; i++) begin
        case (mode_r[2*i +: 2])
          2'b00: m_ledq[i] = new_st[i];
          2'b01: if (m_press[i]) m_ledq[i] = ~m_ledq[i];
          2'b10: begin
            if (clr_r[i])        m_ledq[i] = 1'b0;
            else if (m_press[i]) m_ledq[i] = 1'b1;
          end
          default: if (m_tick) m_ledq[i] = old_st[i];
        endcase
      end
      m_stable = new_st;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("ledclk", 32'(ledCLK), 32'(m_ledclk));
    check("ledq",   32'(ledQ),   32'(m_ledq));
    check("press",  32'(press),  32'(m_press));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Cycles until press[ch] is seen; max+1 on timeout so the caller's check fails.
  task automatic wait_press(input int ch, input int max, output int n);
    n = max + 1;
    for (int i = 1; i <= max; i++) begin
      cycle();
      if (press[ch]) begin n = i; break; end
    end
  endtask

  initial begin
    int n, pulses;
    logic prev_clk, prev_q, saw1;
    logic [2:0] tog_exp;
    int left [CH];

    rst_r = 1'b1; keys_r = '1; mode_r = '0; clr_r = '0;
    run(3);
    check("rst_ledq",  32'(ledQ),   32'd0);
    check("rst_press", 32'(press),  32'd0);
    check("rst_clk",   32'(ledCLK), 32'd0);
    rst_r = 1'b0;

    // Blink: rises after HALF cycles, falls HALF later.
    n = 31;
    for (int i = 1; i <= 30; i++) begin cycle(); if (ledCLK) begin n = i; break; end end
    check("blink_rise", n, HALF);
    n = 31;
    for (int i = 1; i <= 30; i++) begin cycle(); if (!ledCLK) begin n = i; break; end end
    check("blink_half", n, HALF);

    // Debounce on ch0, level mode: short glitch ignored, held press latches.
    keys_r[0] = 1'b0; run(3); keys_r[0] = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin cycle(); pulses += int'(press[0]); end
    check("glitch_press", pulses, 0);
    check("glitch_ledq",  32'(ledQ[0]), 32'd0);
    keys_r[0] = 1'b0;
    wait_press(0, 20, n);
    check("db_latency", n, 2 + DB);
    check("db_ledq",    32'(ledQ[0]), 32'd1);
    cycle();
    check("press_width", 32'(press[0]), 32'd0);
    keys_r[0] = 1'b1;
    n = 21; pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(); pulses += int'(press[0]);
      if (!ledQ[0]) begin n = i; break; end
    end
    check("release_lat",   n, 2 + DB);
    check("release_press", pulses, 0);

    // Toggle on ch1.
    mode_r[3:2] = 2'b01;
    tog_exp = 3'b101;
    for (int p = 0; p < 3; p++) begin
      keys_r[1] = 1'b0;
      wait_press(1, 20, n);
      check("tog_latency", n, 2 + DB);
      check("tog_ledq", 32'(ledQ[1]), 32'(tog_exp[p]));
      cycle();
      check("tog_width", 32'(press[1]), 32'd0);
      keys_r[1] = 1'b1; run(10);
    end

    // Set/clear on ch2.
    mode_r[5:4] = 2'b10;
    keys_r[2] = 1'b0;
    wait_press(2, 20, n);
    check("sr_set", 32'(ledQ[2]), 32'd1);
    keys_r[2] = 1'b1; run(10);
    clr_r[2] = 1'b1; cycle(); clr_r[2] = 1'b0;
    check("sr_clr", 32'(ledQ[2]), 32'd0);
    keys_r[2] = 1'b0; run(2 + DB - 1);
    clr_r[2] = 1'b1; cycle(); clr_r[2] = 1'b0;
    check("sr_both_press", 32'(press[2]), 32'd1);
    check("sr_both_ledq",  32'(ledQ[2]),  32'd0);
    keys_r[2] = 1'b1; run(10);

    // Sample on ch3: LED may only move on blink clock toggles.
    mode_r[7:6] = 2'b11;
    saw1 = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (i == 0)  keys_r[3] = 1'b0;
      if (i == 16) keys_r[3] = 1'b1;
      prev_clk = ledCLK; prev_q = ledQ[3];
      cycle();
      if (ledQ[3] != prev_q)
        check("smp_on_tick", 32'(ledCLK != prev_clk), 32'd1);
      saw1 |= ledQ[3];
    end
    check("smp_seen1", 32'(saw1), 32'd1);
    check("smp_final", 32'(ledQ[3]), 32'd0);

    // Reset mid-operation with ch1 lit and ch0 mid-debounce.
    check("pre_rst_ch1", 32'(ledQ[1]), 32'd1);
    keys_r[0] = 1'b0; run(3);
    rst_r = 1'b1; cycle(); rst_r = 1'b0;
    check("midrst_ledq", 32'(ledQ), 32'd0);
    check("midrst_clk",  32'(ledCLK), 32'd0);
    wait_press(0, 20, n);
    check("rst_held_press", n, 2 + DB);
    keys_r[0] = 1'b1; run(10);

    // Randomized activity.
    for (int i = 0; i < CH; i++) left[i] = $urandom_range(1, 14);
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < CH; i++) begin
        if (left[i] == 0) begin
          keys_r[i] = ~keys_r[i];
          left[i] = $urandom_range(1, 14);
        end else begin
          left[i]--;
        end
      end
      clr_r = ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0;
      if ($urandom_range(0, 199) == 0) mode_r = (2*CH)'($urandom);
      rst_r = ($urandom_range(0, 399) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
